// File: rtl/mux_8x1.sv
// Registered 8-to-1 mux; o captures the input picked by s each clock.
// Optional capture enable and valid flag: define MUX_8X1_EN_VALID_EN.
module mux_8x1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic [2:0]       s,
`ifdef MUX_8X1_EN_VALID_EN
  input  logic             en,
  output logic             valid,
`endif
  output logic [WIDTH-1:0] o
);

  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] o_d;
  logic [WIDTH-1:0] o_q;

  always_comb begin
    sel = '0;
    unique case (s)
      3'd0: sel = a;
      3'd1: sel = b;
      3'd2: sel = c;
      3'd3: sel = d;
      3'd4: sel = e;
      3'd5: sel = f;
      3'd6: sel = g;
      3'd7: sel = h;
      default: sel = '0;
    endcase
  end

`ifdef MUX_8X1_EN_VALID_EN
  logic valid_d;
  logic valid_q;

  // valid marks only the cycle right after a capture
  always_comb begin
    o_d     = o_q;
    valid_d = 1'b0;
    if (en) begin
      o_d     = sel;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      o_q     <= o_d;
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;
`else
  always_comb begin
    o_d = sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_q <= '0;
    else     o_q <= o_d;
  end
`endif

  assign o = o_q;

endmodule

// File: tb/tb_mux_8x1.sv
// Directed bench for mux_8x1: one WIDTH=1 and one WIDTH=8 instance.
module tb_mux_8x1;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] a1, b1, c1, d1, e1, f1, g1, h1;
  logic [2:0] s1;
  logic [0:0] o1;
  logic [7:0] a8, b8, c8, d8, e8, f8, g8, h8;
  logic [2:0] s8;
  logic [7:0] o8;
`ifdef MUX_8X1_EN_VALID_EN
  logic en1, en8, valid1, valid8;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_8x1 #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .e(e1), .f(f1), .g(g1), .h(h1),
    .s(s1),
`ifdef MUX_8X1_EN_VALID_EN
    .en(en1), .valid(valid1),
`endif
    .o(o1)
  );

  mux_8x1 #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .a(a8), .b(b8), .c(c8), .d(d8),
    .e(e8), .f(f8), .g(g8), .h(h8),
    .s(s8),
`ifdef MUX_8X1_EN_VALID_EN
    .en(en8), .valid(valid8),
`endif
    .o(o8)
  );

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp8 [8];
  logic       exp1 [8];

  initial begin
    exp1 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef MUX_8X1_EN_VALID_EN
    en1 = 1'b1;
    en8 = 1'b1;
`endif
    rst = 1'b1;
    {a1, b1, c1, d1, e1, f1, g1, h1} = 8'b1010_1010;
    s1 = 3'd0;
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;
    e8 = 8'h55; f8 = 8'h66; g8 = 8'h77; h8 = 8'h88;
    s8 = 3'd5;
    #1;
    check("rst_o1_init", {7'd0, o1}, 8'h00);
    check("rst_o8_init", o8, 8'h00);
    step();
    check("rst_o8_cyc1", o8, 8'h00);
    step();
    check("rst_o8_cyc2", o8, 8'h00);
    check("rst_o1_cyc2", {7'd0, o1}, 8'h00);
`ifdef MUX_8X1_EN_VALID_EN
    check("rst_valid8", {7'd0, valid8}, 8'h00);
`endif

    rst = 1'b0;
    check("hold_before_edge", o8, 8'h00);
    step();
    check("sel_f_66", o8, 8'h66);
    f8 = 8'hA5;
    step();
    check("sel_f_A5", o8, 8'hA5);

    #2 rst = 1'b1;
    #1;
    check("async_rst_o8", o8, 8'h00);
    check("async_rst_o1", {7'd0, o1}, 8'h00);
    s8 = 3'd7;
    h8 = 8'hFF;
    step();
    check("rst_held_edge", o8, 8'h00);
    #3 rst = 1'b0;
    #1;
    check("rst_rel_no_edge", o8, 8'h00);
    step();
    check("rst_rel_h_FF", o8, 8'hFF);

    f8 = 8'h66;
    h8 = 8'h88;
    for (int i = 0; i < 8; i++) begin
      s1 = 3'(i);
      s8 = 3'(7 - i);
      step();
      check($sformatf("w1_s%0d", i), {7'd0, o1}, {7'd0, exp1[i]});
      check($sformatf("w8_s%0d", 7 - i), o8, exp8[7-i]);
    end

`ifdef MUX_8X1_EN_VALID_EN
    s8 = 3'd2;
    c8 = 8'h3C;
    en8 = 1'b1;
    step();
    check("en1_o8", o8, 8'h3C);
    check("en1_valid", {7'd0, valid8}, 8'h01);
    c8 = 8'hC3;
    en8 = 1'b0;
    step();
    check("en0_o8_hold", o8, 8'h3C);
    check("en0_valid", {7'd0, valid8}, 8'h00);
    en8 = 1'b1;
    step();
    check("en1_again_o8", o8, 8'hC3);
    check("en1_again_valid", {7'd0, valid8}, 8'h01);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
